ahb_ram_slv: RTL and testbench

// - AHB-lite word slave behind the AHB pipeline stage: consumes its registered hsel_ram/haddr/htrans/hwrite/hwdata, returns hready_resp_ram/hrdata.
// - Drives one single-port synchronous SRAM. Writes: zero-wait, posted via a 1-entry write buffer (wbuf). Reads: issued from a registered address.

---
 rtl/ahb_ram_slv_if.sv | 24 ++
 rtl/ahb_ram_slv.sv | 209 ++++++++++++++++++++
 tb/tb_ahb_ram_slv.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_ram_slv_if.sv
// AHB-lite bus bundle between the AHB pipeline stage (master side) and
// the RAM slave. Word transfers only; hsize is not carried.
`timescale 1ns/1ps
interface ahb_ram_slv_if #(
    parameter int ADDR_WID = 21
);
    logic                hsel_ram;
    logic [ADDR_WID-1:0] haddr;
    logic [1:0]          htrans;
    logic                hwrite;
    logic [31:0]         hwdata;
    logic                hready_resp_ram;
    logic [31:0]         hrdata;

    modport master (
        output hsel_ram, haddr, htrans, hwrite, hwdata,
        input  hready_resp_ram, hrdata
    );

    modport slave (
        input  hsel_ram, haddr, htrans, hwrite, hwdata,
        output hready_resp_ram, hrdata
    );
endinterface

// File: rtl/ahb_ram_slv.sv
// AHB-lite word slave in front of a single-port synchronous SRAM.
// Writes are posted through a one-entry write buffer (wbuf) and complete
// with zero wait states; reads stall the bus until the SRAM data has been
// registered into hrdata. A read hitting the pending wbuf entry either
// stalls one cycle so the buffer commits first (default build), or takes
// its data straight from the buffer when AHB_RAM_WBUF_FWD_EN is defined.
//
// All SRAM-side and bus-side outputs are registered: the action for the
// next cycle is decided from the next-state values of the FSM and wbuf.
`timescale 1ns/1ps
module ahb_ram_slv #(
    parameter int ADDR_WID = 21,
    parameter int RAM_AW   = 10,
    parameter int RD_LAT   = 1
) (
    input  logic              hclk,
    input  logic              hrstn,
    ahb_ram_slv_if.slave      bus,
    output logic              o_ram_cs,
    output logic              o_ram_we,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_RD_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                hready_r, hready_nxt_s;
    logic [31:0]         hrdata_r, hrdata_nxt_s;

    logic                wr_pend_r;
    logic [RAM_AW-1:0]   wr_addr_r;
    logic [RAM_AW-1:0]   rd_addr_r, rd_addr_nxt_s;

    logic                wbuf_valid_r, wbuf_valid_nxt_s;
    logic [RAM_AW-1:0]   wbuf_addr_r, wbuf_addr_nxt_s;
    logic [31:0]         wbuf_data_r, wbuf_data_nxt_s;

    logic                ram_cs_r, ram_cs_nxt_s;
    logic                ram_we_r, ram_we_nxt_s;
    logic [RAM_AW-1:0]   ram_addr_r, ram_addr_nxt_s;
    logic [31:0]         ram_wdata_r, ram_wdata_nxt_s;

    logic                accept_s;
    logic                accept_rd_s;
    logic [RAM_AW-1:0]   word_addr_s;
    logic                commit_cur_s;
    logic                hit_s;
    logic                hit_nxt_s;
    logic                unused_s;

    // Byte address to word index; upper address bits alias.
    assign word_addr_s  = bus.haddr[RAM_AW+1:2];
    assign accept_s     = bus.hsel_ram & bus.htrans[1] & hready_r;
    assign accept_rd_s  = accept_s & ~bus.hwrite;
    // The registered SRAM strobes describe what is happening this cycle.
    assign commit_cur_s = ram_cs_r & ram_we_r;
    assign hit_s        = wbuf_valid_r & (wbuf_addr_r == rd_addr_r);
    assign unused_s     = ^{bus.haddr[ADDR_WID-1:RAM_AW+2], bus.haddr[1:0], bus.htrans[0]};

    // Read FSM next state, latency counter and read-data capture.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        hrdata_nxt_s = hrdata_r;
        case (state_r)
            ST_IDLE, ST_RD_DONE: begin
                if (accept_rd_s) begin
                    state_nxt_s = ST_RD_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                if (hit_s) begin
`ifdef AHB_RAM_WBUF_FWD_EN
                    // Buffered data is the freshest copy; the SRAM is busy committing it.
                    hrdata_nxt_s = wbuf_data_r;
                    state_nxt_s  = ST_RD_DONE;
`else
                    // This cycle commits the wbuf; retry the read next cycle.
                    state_nxt_s  = ST_RD_ISSUE;
`endif
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                    cnt_nxt_s   = CNT_W'(RD_LAT - 1);
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    hrdata_nxt_s = i_ram_rdata;
                    state_nxt_s  = ST_RD_DONE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Write-buffer load/drain and latched transfer addresses.
    always_comb begin
        wbuf_valid_nxt_s = wbuf_valid_r;
        wbuf_addr_nxt_s  = wbuf_addr_r;
        wbuf_data_nxt_s  = wbuf_data_r;
        if (wr_pend_r) begin
            // A finishing write data phase refills the buffer even while it commits.
            wbuf_valid_nxt_s = 1'b1;
            wbuf_addr_nxt_s  = wr_addr_r;
            wbuf_data_nxt_s  = bus.hwdata;
        end else if (commit_cur_s) begin
            wbuf_valid_nxt_s = 1'b0;
        end else begin
            wbuf_valid_nxt_s = wbuf_valid_r;
        end

        if (accept_rd_s) begin
            rd_addr_nxt_s = word_addr_s;
        end else begin
            rd_addr_nxt_s = rd_addr_r;
        end
    end

    // Next-cycle SRAM command: a read being issued wins, otherwise drain the wbuf.
    always_comb begin
        hit_nxt_s       = wbuf_valid_nxt_s & (wbuf_addr_nxt_s == rd_addr_nxt_s);
        ram_cs_nxt_s    = 1'b0;
        ram_we_nxt_s    = 1'b0;
        ram_addr_nxt_s  = ram_addr_r;
        ram_wdata_nxt_s = ram_wdata_r;
        if ((state_nxt_s == ST_RD_ISSUE) && !hit_nxt_s) begin
            ram_cs_nxt_s   = 1'b1;
            ram_we_nxt_s   = 1'b0;
            ram_addr_nxt_s = rd_addr_nxt_s;
        end else if (wbuf_valid_nxt_s) begin
            ram_cs_nxt_s    = 1'b1;
            ram_we_nxt_s    = 1'b1;
            ram_addr_nxt_s  = wbuf_addr_nxt_s;
            ram_wdata_nxt_s = wbuf_data_nxt_s;
        end else begin
            ram_cs_nxt_s = 1'b0;
            ram_we_nxt_s = 1'b0;
        end
        hready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RD_DONE);
    end

    // FSM state, counter and bus response registers.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            hready_r <= 1'b1;
            hrdata_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            hready_r <= hready_nxt_s;
            hrdata_r <= hrdata_nxt_s;
        end
    end

    // Address-phase latches, write buffer and SRAM command registers.
    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            wr_pend_r    <= 1'b0;
            wr_addr_r    <= {RAM_AW{1'b0}};
            rd_addr_r    <= {RAM_AW{1'b0}};
            wbuf_valid_r <= 1'b0;
            wbuf_addr_r  <= {RAM_AW{1'b0}};
            wbuf_data_r  <= 32'h0000_0000;
            ram_cs_r     <= 1'b0;
            ram_we_r     <= 1'b0;
            ram_addr_r   <= {RAM_AW{1'b0}};
            ram_wdata_r  <= 32'h0000_0000;
        end else begin
            wr_pend_r    <= accept_s & bus.hwrite;
            if (accept_s & bus.hwrite) begin
                wr_addr_r <= word_addr_s;
            end
            rd_addr_r    <= rd_addr_nxt_s;
            wbuf_valid_r <= wbuf_valid_nxt_s;
            wbuf_addr_r  <= wbuf_addr_nxt_s;
            wbuf_data_r  <= wbuf_data_nxt_s;
            ram_cs_r     <= ram_cs_nxt_s;
            ram_we_r     <= ram_we_nxt_s;
            ram_addr_r   <= ram_addr_nxt_s;
            ram_wdata_r  <= ram_wdata_nxt_s;
        end
    end

    assign bus.hready_resp_ram = hready_r;
    assign bus.hrdata          = hrdata_r;
    assign o_ram_cs            = ram_cs_r;
    assign o_ram_we            = ram_we_r;
    assign o_ram_addr          = ram_addr_r;
    assign o_ram_wdata         = ram_wdata_r;

endmodule

// File: tb/tb_ahb_ram_slv.sv
// Directed testbench for ahb_ram_slv with a 1-cycle-latency SRAM model.
// Inputs are driven and outputs sampled 1 ns after the rising edge, so a
// sample taken after the k-th edge shows the cycle-k values.
`timescale 1ns/1ps
module tb_ahb_ram_slv;

    logic        hclk = 1'b0;
    logic        hrstn;
    logic        ram_cs;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem_r [0:1023];

    int checks = 0;
    int failures = 0;

    ahb_ram_slv_if #(.ADDR_WID(21)) bus ();

    ahb_ram_slv #(.ADDR_WID(21), .RAM_AW(10), .RD_LAT(1)) dut (
        .hclk        (hclk),
        .hrstn       (hrstn),
        .bus         (bus.slave),
        .o_ram_cs    (ram_cs),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    always #5 hclk = ~hclk;

    // Single-port synchronous SRAM, read data one cycle after chip select.
    always @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            for (int i = 0; i < 1024; i++) mem_r[i] <= 32'h0000_0000;
            ram_rdata <= 32'h0000_0000;
        end else if (ram_cs) begin
            if (ram_we) mem_r[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem_r[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic bus_idle();
        bus.hsel_ram = 1'b0;
        bus.htrans   = 2'b00;
        bus.hwrite   = 1'b0;
    endtask

    task automatic addr_phase(input logic wr, input logic [20:0] a);
        bus.hsel_ram = 1'b1;
        bus.htrans   = 2'b10;
        bus.hwrite   = wr;
        bus.haddr    = a;
    endtask

    // Complete one write and let the wbuf drain.
    task automatic do_write(input logic [20:0] a, input logic [31:0] d);
        addr_phase(1'b1, a);
        step();
        bus_idle();
        bus.hwdata = d;
        step();
        step();
        step();
    endtask

    initial begin
        bus_idle();
        bus.haddr  = 21'd0;
        bus.hwdata = 32'h0000_0000;
        hrstn = 1'b0;
        step();
        step();
        check("rst_hready", 32'(bus.hready_resp_ram), 32'd1);
        check("rst_hrdata", bus.hrdata, 32'h0000_0000);
        check("rst_cs", 32'(ram_cs), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", ram_wdata, 32'h0000_0000);
        hrstn = 1'b1;
        step();

        // Posted write 0x10 = 0xDEADBEEF
        addr_phase(1'b1, 21'h00010);
        check("w1_hready_a", 32'(bus.hready_resp_ram), 32'd1);
        step();
        bus_idle();
        bus.hwdata = 32'hDEAD_BEEF;
        check("w1_hready_a1", 32'(bus.hready_resp_ram), 32'd1);
        check("w1_cs_a1", 32'(ram_cs), 32'd0);
        step();
        check("w1_cs", 32'(ram_cs), 32'd1);
        check("w1_we", 32'(ram_we), 32'd1);
        check("w1_addr", 32'(ram_addr), 32'd4);
        check("w1_wdata", ram_wdata, 32'hDEAD_BEEF);
        step();
        check("w1_cs_off", 32'(ram_cs), 32'd0);

        // Preload words for the read tests
        do_write(21'h00020, 32'h1234_5678);
        do_write(21'h00080, 32'hCAFE_F00D);

        // Plain read 0x20
        addr_phase(1'b0, 21'h00020);
        step();
        bus_idle();
        check("r_cs", 32'(ram_cs), 32'd1);
        check("r_we", 32'(ram_we), 32'd0);
        check("r_addr", 32'(ram_addr), 32'd8);
        check("r_hready_r1", 32'(bus.hready_resp_ram), 32'd0);
        step();
        check("r_hready_r2", 32'(bus.hready_resp_ram), 32'd0);
        step();
        check("r_hready_r3", 32'(bus.hready_resp_ram), 32'd1);
        check("r_hrdata", bus.hrdata, 32'h1234_5678);
        step();

        // Write 0x40 then read 0x40 (RAW hit on the wbuf)
        addr_phase(1'b1, 21'h00040);
        step();
        addr_phase(1'b0, 21'h00040);
        bus.hwdata = 32'h0000_A5A5;
        check("raw_hready_a1", 32'(bus.hready_resp_ram), 32'd1);
        step();
        bus_idle();
        check("raw_commit_cs", 32'(ram_cs), 32'd1);
        check("raw_commit_we", 32'(ram_we), 32'd1);
        check("raw_commit_addr", 32'(ram_addr), 32'h10);
        check("raw_hready_a2", 32'(bus.hready_resp_ram), 32'd0);
        step();
`ifdef AHB_RAM_WBUF_FWD_EN
        check("fwd_no_read", 32'(ram_cs), 32'd0);
        check("fwd_hready_a3", 32'(bus.hready_resp_ram), 32'd1);
        check("fwd_hrdata", bus.hrdata, 32'h0000_A5A5);
`else
        check("raw_read_cs", 32'(ram_cs), 32'd1);
        check("raw_read_we", 32'(ram_we), 32'd0);
        check("raw_read_addr", 32'(ram_addr), 32'h10);
        check("raw_hready_a3", 32'(bus.hready_resp_ram), 32'd0);
        step();
        check("raw_hready_a4", 32'(bus.hready_resp_ram), 32'd0);
        step();
        check("raw_hready_a5", 32'(bus.hready_resp_ram), 32'd1);
        check("raw_hrdata", bus.hrdata, 32'h0000_A5A5);
`endif
        step();

        // Write 0x40 then read 0x80 (miss: read first, commit after)
        addr_phase(1'b1, 21'h00040);
        step();
        addr_phase(1'b0, 21'h00080);
        bus.hwdata = 32'h1111_2222;
        step();
        bus_idle();
        check("miss_rd_cs", 32'(ram_cs), 32'd1);
        check("miss_rd_we", 32'(ram_we), 32'd0);
        check("miss_rd_addr", 32'(ram_addr), 32'h20);
        step();
        check("miss_wr_we", 32'(ram_we), 32'd1);
        check("miss_wr_addr", 32'(ram_addr), 32'h10);
        check("miss_wr_data", ram_wdata, 32'h1111_2222);
        check("miss_hready_a3", 32'(bus.hready_resp_ram), 32'd0);
        step();
        check("miss_hready_a4", 32'(bus.hready_resp_ram), 32'd1);
        check("miss_hrdata", bus.hrdata, 32'hCAFE_F00D);
        step();

        // Back-to-back writes, last one aliased above the RAM size
        addr_phase(1'b1, 21'h00100);
        step();
        addr_phase(1'b1, 21'h00104);
        bus.hwdata = 32'hA000_0000;
        step();
        addr_phase(1'b1, 21'h01010);
        bus.hwdata = 32'hA000_0001;
        check("b2b_addr0", 32'(ram_addr), 32'h40);
        check("b2b_data0", ram_wdata, 32'hA000_0000);
        check("b2b_hready", 32'(bus.hready_resp_ram), 32'd1);
        step();
        bus_idle();
        bus.hwdata = 32'hA000_0002;
        check("b2b_addr1", 32'(ram_addr), 32'h41);
        check("b2b_data1", ram_wdata, 32'hA000_0001);
        step();
        check("b2b_alias_addr", 32'(ram_addr), 32'h4);
        check("b2b_alias_we", 32'(ram_we), 32'd1);
        check("b2b_data2", ram_wdata, 32'hA000_0002);
        step();
        check("b2b_drained", 32'(ram_cs), 32'd0);

        // IDLE then BUSY with hsel high: no transfer
        bus.hsel_ram = 1'b1;
        bus.hwrite   = 1'b1;
        bus.haddr    = 21'h00200;
        bus.htrans   = 2'b00;
        step();
        bus.htrans   = 2'b01;
        check("idle_cs", 32'(ram_cs), 32'd0);
        step();
        check("busy_cs", 32'(ram_cs), 32'd0);
        check("busy_hready", 32'(bus.hready_resp_ram), 32'd1);
        step();
        check("busy_cs2", 32'(ram_cs), 32'd0);
        bus_idle();

        // Asynchronous reset in the middle of a read
        addr_phase(1'b0, 21'h00020);
        step();
        bus_idle();
        hrstn = 1'b0;
        #1;
        check("midrst_hready", 32'(bus.hready_resp_ram), 32'd1);
        check("midrst_cs", 32'(ram_cs), 32'd0);
        hrstn = 1'b1;
        step();
        step();
        check("midrst_idle_cs", 32'(ram_cs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
